// File: rtl/fib_pkg.sv
// ============================================================================
// fib_pkg : shared types and helpers for the fib_server compute block
// Revision: 1.0
// ============================================================================
`default_nettype none

package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int NREQ_DEFAULT = 2;
  localparam int ID_W_DEFAULT = $clog2(NREQ_DEFAULT);

  // Largest value representable in an n-bit unsigned result.
  function automatic logic [63:0] fib_max(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // Requester-id width; never zero so a 1-requester build still has a port.
  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fib_rr_arbiter.sv
// ============================================================================
// fib_rr_arbiter : combinational round-robin pick starting at a pointer
// Revision: 1.0
// ============================================================================
`default_nettype none

module fib_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_grant_idx,
  output logic            o_any
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  // First asserted request at or after the pointer, wrapping around.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i_en && !o_any && i_req[wrap_idx(int'(i_ptr), i)]) begin
        o_any                               = 1'b1;
        o_grant[wrap_idx(int'(i_ptr), i)]   = 1'b1;
        o_grant_idx                         = ID_W'(wrap_idx(int'(i_ptr), i));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fib_server.sv
// ============================================================================
// fib_server : arbitrated on-demand F(k) server with saturating N-bit result
// Revision: 1.0
// ============================================================================
`default_nettype none

module fib_server
  import fib_pkg::*;
#(
  parameter int N    = 13,
  parameter int IW   = 5,
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*IW-1:0]      i_req_idx,
  output logic [NREQ-1:0]         o_req_ready,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [id_w(NREQ)-1:0]   o_rsp_id,
  output logic [N-1:0]            o_rsp_fn,
  output logic                    o_rsp_ovf
);

  localparam int         ID_W  = id_w(NREQ);
  localparam logic [N:0] c_max = (N+1)'(fib_max(N));

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [IW-1:0]     r_cnt;
  logic [N:0]        r_a;
  logic [N:0]        r_b;
  logic              r_ovf_a;
  logic              r_ovf_b;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [N-1:0]      r_rsp_fn;
  logic              r_rsp_ovf;

  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_grant_any;
  logic              w_arb_en;
  logic [IW-1:0]     w_sel_idx;
  logic [ID_W-1:0]   w_ptr_next;
  logic [N:0]        w_sum;
  logic              w_a_ovf;

  // Grants only in IDLE, and never while reset is held.
  assign w_arb_en = (r_state == ST_IDLE) && !reset;

  fib_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .i_en        (w_arb_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_grant_any)
  );

  assign w_sel_idx  = i_req_idx[int'(w_grant_idx)*IW +: IW];
  assign w_ptr_next = (int'(w_grant_idx) == NREQ-1) ? '0 : ID_W'(w_grant_idx + 1'b1);
  assign w_sum      = r_a + r_b;
  // Sticky flag covers values that already wrapped and can no longer be compared.
  assign w_a_ovf    = r_ovf_a | (r_a > c_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_any)  w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == '0)  w_state_nxt = ST_RESP;
      ST_RESP: if (i_rsp_ready)  w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= (N+1)'(1);
      r_ovf_a     <= 1'b0;
      r_ovf_b     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_fn    <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_cnt   <= w_sel_idx;
            r_id    <= w_grant_idx;
            r_a     <= '0;
            r_b     <= (N+1)'(1);
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
            r_ptr   <= w_ptr_next;
          end
        end
        ST_RUN: begin
          if (r_cnt != '0) begin
            r_a     <= r_b;
            r_b     <= w_sum;
            r_cnt   <= r_cnt - 1'b1;
            r_ovf_a <= r_ovf_b;
            r_ovf_b <= r_ovf_b | (w_sum > c_max);
          end else begin
            r_rsp_fn    <= w_a_ovf ? c_max[N-1:0] : r_a[N-1:0];
            r_rsp_ovf   <= w_a_ovf;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_fn    = r_rsp_fn;
  assign o_rsp_ovf   = r_rsp_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fib_server.sv
// ============================================================================
// tb_fib_server : directed + randomized checks of fib_server against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fib_server;

  localparam int     N    = 13;
  localparam int     IW   = 5;
  localparam int     NREQ = 2;
  localparam longint MAXV = (64'sd1 <<< N) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*IW-1:0]  req_idx;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [0:0]          rsp_id;
  logic [N-1:0]        rsp_fn;
  logic                rsp_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  fib_server #(.N(N), .IW(IW), .NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (req_valid),
    .i_req_idx   (req_idx),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_fn    (rsp_fn),
    .o_rsp_ovf   (rsp_ovf)
  );

  function automatic longint fib_true(input int k);
    longint a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [63:0] exp_fn(input int k);
    return (fib_true(k) > MAXV) ? MAXV : fib_true(k);
  endfunction

  function automatic logic [63:0] exp_ovf(input int k);
    return (fib_true(k) > MAXV) ? 64'd1 : 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int k);
    req_valid[r]         = 1'b1;
    req_idx[r*IW +: IW]  = IW'(k);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // One request from a lone requester, response taken immediately.
  task automatic single_txn(input int r, input int k);
    int lat;
    set_req(r, k);
    #1;
    check("req_ready_idle", req_ready, 64'd1 << r);
    tick();
    req_valid[r] = 1'b0;
    m_ptr = (r + 1) % NREQ;
    check("req_ready_busy", req_ready, 0);
    wait_rsp(lat);
    check("latency", lat, k + 1);
    check("rsp_fn", rsp_fn, exp_fn(k));
    check("rsp_ovf", rsp_ovf, exp_ovf(k));
    check("rsp_id", rsp_id, r);
    tick();
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  // Both requesters continuously valid; the model picks the pointer holder.
  task automatic pair_loop(input int k0, input int k1, input int cnt);
    int lat, w, kw;
    set_req(0, k0);
    set_req(1, k1);
    for (int t = 0; t < cnt; t++) begin
      w  = m_ptr;
      kw = (w == 0) ? k0 : k1;
      #1;
      check("pair_req_ready", req_ready, 64'd1 << w);
      tick();
      m_ptr = (w + 1) % NREQ;
      wait_rsp(lat);
      check("pair_latency", lat, kw + 1);
      check("pair_rsp_id", rsp_id, w);
      check("pair_rsp_fn", rsp_fn, exp_fn(kw));
      tick();
    end
    req_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] hold_fn;
    logic [0:0]   hold_id;
    int           lat;

    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_idx   = '0;
    set_req(0, 5);
    set_req(1, 7);
    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_fn", rsp_fn, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_ovf", rsp_ovf, 0);
    check("reset_req_ready", req_ready, 0);
    tick();
    tick();
    reset = 1'b0;

    pair_loop(5, 7, 4);

    single_txn(0, 20);
    single_txn(0, 0);
    single_txn(1, 1);
    single_txn(0, 2);
    single_txn(1, 21);
    single_txn(0, 31);
    single_txn(0, 20);
    single_txn(1, 13);

    repeat (16) single_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
    pair_loop(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 4);

    // Response back-pressure with another request waiting.
    rsp_ready = 1'b0;
    set_req(0, 9);
    #1;
    check("bp_req_ready", req_ready, 1);
    tick();
    req_valid[0] = 1'b0;
    m_ptr = 1;
    set_req(1, 3);
    wait_rsp(lat);
    check("bp_latency", lat, 10);
    check("bp_rsp_fn", rsp_fn, exp_fn(9));
    hold_fn = rsp_fn;
    hold_id = rsp_id;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_fn", rsp_fn, hold_fn);
      check("bp_hold_id", rsp_id, hold_id);
      check("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_released", rsp_valid, 0);
    check("bp_idle_grant", req_ready, 2);
    tick();
    req_valid[1] = 1'b0;
    m_ptr = 0;
    wait_rsp(lat);
    check("bp_next_latency", lat, 4);
    check("bp_next_fn", rsp_fn, exp_fn(3));
    check("bp_next_id", rsp_id, 1);
    tick();

    // Abort a computation with reset; pointer must return to 0.
    set_req(0, 15);
    #1;
    tick();
    req_valid[0] = 1'b0;
    m_ptr = 1;
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    m_ptr = 0;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_fn", rsp_fn, 0);
    check("abort_rsp_id", rsp_id, 0);
    check("abort_rsp_ovf", rsp_ovf, 0);
    check("abort_req_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_no_rsp", rsp_valid, 0);
    end
    pair_loop(10, 10, 2);
    single_txn(1, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
